// File: rtl/fillrect.sv
// Rectangle fill engine: scans a clipped rectangle in row-major order and emits
// one pixel write per cycle, with a stall input and four colour patterns.
module fillrect #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int XW       = 8,
    parameter int YW       = 7,
    parameter int CW       = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] w,
    input  logic [YW-1:0] h,
    input  logic [CW-1:0] colour,
    input  logic [1:0]    mode,
    input  logic          hold,
    output logic          done,
    output logic          busy,
    output logic [XW-1:0] vga_x,
    output logic [YW-1:0] vga_y,
    output logic [CW-1:0] vga_colour,
    output logic          vga_plot
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

    localparam int MW = XW + YW + 1;

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [XW-1:0] x0_q, x0_d;
    logic [XW-1:0] xe_q, xe_d;
    logic [YW-1:0] ye_q, ye_d;
    logic [CW-1:0] colour_q, colour_d;
    logic [1:0]    mode_q, mode_d;

    // End corner is formed one bit wider so x0+w-1 cannot wrap before clipping.
    logic [XW:0]   x_end_raw, x_end_clip;
    logic [YW:0]   y_end_raw, y_end_clip;
    logic          degenerate;
    logic          x_last, y_last;
    logic [MW-1:0] colour_mix;

    always_comb begin
        x_end_raw  = {1'b0, x0} + {1'b0, w} - (XW+1)'(1);
        y_end_raw  = {1'b0, y0} + {1'b0, h} - (YW+1)'(1);
        x_end_clip = (x_end_raw > (XW+1)'(SCREEN_W - 1)) ? (XW+1)'(SCREEN_W - 1) : x_end_raw;
        y_end_clip = (y_end_raw > (YW+1)'(SCREEN_H - 1)) ? (YW+1)'(SCREEN_H - 1) : y_end_raw;
        degenerate = (w == '0) || (h == '0) ||
                     ({1'b0, x0} >= (XW+1)'(SCREEN_W)) ||
                     ({1'b0, y0} >= (YW+1)'(SCREEN_H));
        x_last     = (x_q == xe_q);
        y_last     = (y_q == ye_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q      <= '0;
            y_q      <= '0;
            x0_q     <= '0;
            xe_q     <= '0;
            ye_q     <= '0;
            colour_q <= '0;
            mode_q   <= '0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            x0_q     <= x0_d;
            xe_q     <= xe_d;
            ye_q     <= ye_d;
            colour_q <= colour_d;
            mode_q   <= mode_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        x0_d     = x0_q;
        xe_d     = xe_q;
        ye_d     = ye_q;
        colour_d = colour_q;
        mode_d   = mode_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (degenerate) begin
                        state_d = S_DONE;
                    end else begin
                        state_d  = S_FILL;
                        x_d      = x0;
                        y_d      = y0;
                        x0_d     = x0;
                        xe_d     = x_end_clip[XW-1:0];
                        ye_d     = y_end_clip[YW-1:0];
                        colour_d = colour;
                        mode_d   = mode;
                    end
                end
            end
            S_FILL: begin
                if (!hold) begin
                    if (x_last) begin
                        if (y_last) begin
                            state_d = S_DONE;
                        end else begin
                            x_d = x0_q;
                            y_d = y_q + YW'(1);
                        end
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
            end
            S_DONE: begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q == S_FILL);
        done       = (state_q == S_DONE);
        vga_plot   = busy && !hold;
        vga_x      = x_q;
        vga_y      = y_q;
        colour_mix = MW'(colour_q)
                   + (mode_q[0] ? MW'(x_q) : MW'(0))
                   + (mode_q[1] ? MW'(y_q) : MW'(0));
        vga_colour = colour_mix[CW-1:0];
    end

endmodule

// File: tb/tb_fillrect.sv
// Randomized self-checking bench for fillrect: a pixel-list reference model
// predicts every output cycle; directed scenarios pin the model with literals.
module tb_fillrect;

  localparam int SW = 160;
  localparam int SH = 120;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;
  localparam int W  = XW + YW + CW;

  localparam int P_IDLE = 0;
  localparam int P_FILL = 1;
  localparam int P_DONE = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [XW-1:0] x0 = '0;
  logic [YW-1:0] y0 = '0;
  logic [XW-1:0] w = '0;
  logic [YW-1:0] h = '0;
  logic [CW-1:0] colour = '0;
  logic [1:0]    mode = '0;
  logic          hold = 1'b0;
  logic          done, busy, vga_plot;
  logic [XW-1:0] vga_x;
  logic [YW-1:0] vga_y;
  logic [CW-1:0] vga_colour;

  int total = 0;
  int bad = 0;

  // reference model state
  logic [W-1:0] exp_q[$];
  int m_phase = P_IDLE;

  // observed results
  int plot_cnt = 0;
  int last_x = -1;
  int last_y = -1;
  logic [XW+YW-1:0] plot_seq[$];
  logic [CW-1:0] img [0:SW*SH-1];
  int hits [0:SW*SH-1];

  fillrect #(.SCREEN_W(SW), .SCREEN_H(SH), .XW(XW), .YW(YW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .x0(x0), .y0(y0), .w(w), .h(h),
    .colour(colour), .mode(mode), .hold(hold), .done(done), .busy(busy),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  // clock block
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pix_colour(input int c, input int m, input int xx, input int yy);
    return (c + ((m & 1) != 0 ? xx : 0) + ((m & 2) != 0 ? yy : 0)) % (1 << CW);
  endfunction

  function automatic int expected_plots(input int ax0, input int ay0, input int aw, input int ah);
    int xe, ye;
    if (aw == 0 || ah == 0 || ax0 >= SW || ay0 >= SH) return 0;
    xe = (ax0 + aw - 1 < SW - 1) ? ax0 + aw - 1 : SW - 1;
    ye = (ay0 + ah - 1 < SH - 1) ? ay0 + ah - 1 : SH - 1;
    return (xe - ax0 + 1) * (ye - ay0 + 1);
  endfunction

  // reference model: the list of pixels a request must produce, consumed as they are plotted
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = P_IDLE;
      exp_q.delete();
    end else begin
      case (m_phase)
        P_IDLE: if (start) begin
          int ax0, ay0, xe, ye;
          ax0 = int'(x0);
          ay0 = int'(y0);
          if (expected_plots(ax0, ay0, int'(w), int'(h)) > 0) begin
            xe = (ax0 + int'(w) - 1 < SW - 1) ? ax0 + int'(w) - 1 : SW - 1;
            ye = (ay0 + int'(h) - 1 < SH - 1) ? ay0 + int'(h) - 1 : SH - 1;
            for (int yy = ay0; yy <= ye; yy++)
              for (int xx = ax0; xx <= xe; xx++)
                exp_q.push_back({XW'(xx), YW'(yy),
                                 CW'(pix_colour(int'(colour), int'(mode), xx, yy))});
          end
          m_phase = (exp_q.size() > 0) ? P_FILL : P_DONE;
        end
        P_FILL: if (!hold) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) m_phase = P_DONE;
        end
        default: if (!start) m_phase = P_IDLE;
      endcase
    end
  end

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_done", int'(done), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_plot", int'(vga_plot), 0);
      chk("rst_x", int'(vga_x), 0);
      chk("rst_y", int'(vga_y), 0);
    end else begin
      chk("done", int'(done), int'(m_phase == P_DONE));
      chk("busy", int'(busy), int'(m_phase == P_FILL));
      chk("plot", int'(vga_plot), int'(m_phase == P_FILL && !hold));
      if (m_phase == P_FILL && exp_q.size() > 0) begin
        chk("pixel", int'({vga_x, vga_y, vga_colour}), int'(exp_q[0]));
      end
      if (vga_plot) begin
        plot_cnt++;
        last_x = int'(vga_x);
        last_y = int'(vga_y);
        plot_seq.push_back({vga_x, vga_y});
        if (int'(vga_x) >= SW || int'(vga_y) >= SH) begin
          chk("on_screen", 0, 1);
        end else begin
          if (hits[int'(vga_y) * SW + int'(vga_x)] != 0) chk("no_duplicate", 1, 0);
          hits[int'(vga_y) * SW + int'(vga_x)]++;
          img[int'(vga_y) * SW + int'(vga_x)] = vga_colour;
        end
      end
    end
  end

  task automatic clear_obs();
    plot_cnt = 0;
    last_x = -1;
    last_y = -1;
    plot_seq.delete();
    for (int i = 0; i < SW * SH; i++) begin
      hits[i] = 0;
      img[i] = '0;
    end
  endtask

  // driver: one complete request; hmode 0 no stall, 1 random stall, 2 stall cycles 3..5
  task automatic run_rect(input int ax0, input int ay0, input int aw, input int ah,
                          input int acol, input int amode, input int hmode,
                          output int cyc);
    bit seen;
    int n;
    int holds;
    seen = 0;
    cyc = 0;
    holds = 0;
    n = expected_plots(ax0, ay0, aw, ah);
    clear_obs();
    @(posedge clk); #1;
    x0 = XW'(ax0); y0 = YW'(ay0); w = XW'(aw); h = YW'(ah);
    colour = CW'(acol); mode = 2'(amode); hold = 1'b0; start = 1'b1;
    while (!seen && cyc < 30000) begin
      @(posedge clk); #1;
      cyc++;
      x0 = XW'($urandom); y0 = YW'($urandom); w = XW'($urandom); h = YW'($urandom);
      colour = CW'($urandom); mode = 2'($urandom);
      case (hmode)
        1: hold = ($urandom_range(0, 3) == 0);
        2: hold = (cyc >= 3 && cyc <= 5);
        default: hold = 1'b0;
      endcase
      @(negedge clk);
      if (done) seen = 1;
      else if (hold) holds++;
    end
    chk("done_reached", int'(seen), 1);
    chk("plot_count", plot_cnt, n);
    chk("done_latency", cyc, n + holds + 1);
    hold = 1'b0;
    repeat ($urandom_range(1, 3)) begin
      @(posedge clk); #1;
    end
    start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_after_start_low", int'(done), 0);
  endtask

  initial begin
    int cyc;
    int off;
    clear_obs();
    // reset block
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // full screen, solid colour
    run_rect(0, 0, 160, 120, 5, 0, 0, cyc);
    chk("full_plots", plot_cnt, 19200);
    chk("full_last_x", last_x, 159);
    chk("full_last_y", last_y, 119);
    chk("full_done_cycle", cyc, 19201);
    off = 0;
    for (int i = 0; i < SW * SH; i++) if (img[i] != 3'd5) off++;
    chk("full_all_colour5", off, 0);

    // clipping at the bottom-right corner
    run_rect(150, 115, 20, 20, 1, 1, 0, cyc);
    chk("clip_plots", plot_cnt, 50);
    chk("clip_last_x", last_x, 159);
    chk("clip_last_y", last_y, 119);

    // degenerate requests
    run_rect(10, 10, 0, 5, 3, 0, 0, cyc);
    chk("degen_w0_cycle", cyc, 1);
    chk("degen_w0_plots", plot_cnt, 0);
    run_rect(200, 10, 5, 5, 3, 0, 0, cyc);
    chk("degen_x200_cycle", cyc, 1);
    chk("degen_x200_plots", plot_cnt, 0);

    // stall after the second pixel
    run_rect(10, 10, 4, 2, 0, 0, 2, cyc);
    chk("stall_plots", plot_cnt, 8);
    chk("stall_after_hold", int'(plot_seq[2]), int'({8'd12, 7'd10}));

    // diagonal mode literals
    run_rect(0, 0, 8, 2, 2, 3, 0, cyc);
    chk("mode3_px_7_1", int'(img[1 * SW + 7]), 2);
    chk("mode3_px_3_0", int'(img[0 * SW + 3]), 5);

    // randomized requests with random stalls
    for (int t = 0; t < 14; t++) begin
      run_rect($urandom_range(0, 170), $urandom_range(0, 125), $urandom_range(0, 40),
               $urandom_range(0, 20), $urandom_range(0, 7), $urandom_range(0, 3), 1, cyc);
    end

    // reset in the middle of a fill
    clear_obs();
    @(posedge clk); #1;
    x0 = 8'd0; y0 = 7'd0; w = 8'd160; h = 7'd120; colour = 3'd4; mode = 2'd0; start = 1'b1;
    cyc = 0;
    while (plot_cnt < 100 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_reached_100", plot_cnt, 100);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_plot", int'(vga_plot), 0);
    chk("async_rst_x", int'(vga_x), 0);
    chk("async_rst_y", int'(vga_y), 0);
    chk("async_rst_done", int'(done), 0);
    repeat (3) @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    run_rect(20, 30, 5, 3, 6, 1, 0, cyc);
    chk("after_rst_first", int'(plot_seq[0]), int'({8'd20, 7'd30}));
    chk("after_rst_plots", plot_cnt, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fillrect.md
FILLRECT -- requirements
Module: fillrect

Interface
REQ-001 Parameter SCREEN_W, default 160, meaning visible columns.
REQ-002 Parameter SCREEN_H, default 120, meaning visible rows.
REQ-003 Parameter XW, default 8, meaning x coordinate/width bit-width.
REQ-004 Parameter YW, default 7, meaning y coordinate/height bit-width.
REQ-005 Parameter CW, default 3, meaning colour bit-width.
REQ-006 Port clk  input  1  the single clock; all logic rising-edge.
REQ-007 Port rst  input  1  reset, asynchronous, active-high.
REQ-008 Port start  input  1  request; held high until done seen.
REQ-009 Port x0, y0  input  XW, YW  rectangle top-left corner.
REQ-010 Port w, h  input  XW, YW  rectangle width and height in pixels.
REQ-011 Port colour  input  CW  base colour.
REQ-012 Port mode  input  2  colour mode: 0 solid, 1 x-stripe, 2 y-stripe, 3 diagonal.
REQ-013 Port hold  input  1  stall; freezes the scan while high.
REQ-014 Port done  output  1  fill complete.
REQ-015 Port busy  output  1  high in FILL state.
REQ-016 Port vga_x, vga_y  output  XW, YW  pixel coordinate.
REQ-017 Port vga_colour  output  CW  pixel colour.
REQ-018 Port vga_plot  output  1  pixel write strobe.

Function
REQ-019 The FSM SHALL have states IDLE, FILL, DONE.
REQ-020 In IDLE with start=1, the block SHALL latch x0, y0, colour and mode, compute the clipped end corner xe=min(x0+w-1, SCREEN_W-1) and ye=min(y0+h-1, SCREEN_H-1) at XW+1/YW+1 bits (no overflow), and go to FILL.
REQ-021 If w=0, h=0, x0>=SCREEN_W or y0>=SCREEN_H, the IDLE->start transition SHALL go directly to DONE with zero plots.
REQ-022 The first plot (vga_x=x0, vga_y=y0, vga_plot=1) SHALL occur in the cycle after start is sampled.
REQ-023 In FILL with hold=0, the block SHALL plot one pixel per cycle in row-major order: x increments; at x=xe, x reloads x0 and y increments.
REQ-024 In FILL with hold=1, vga_plot SHALL be 0 and vga_x/vga_y SHALL be frozen; scanning resumes at the same pixel when hold falls.
REQ-025 After the pixel (xe,ye) is plotted, the next state SHALL be DONE, with vga_plot=0.
REQ-026 Total plot strobes SHALL equal (xe-x0+1)*(ye-y0+1); no pixel is plotted twice or outside the screen.
REQ-027 vga_colour SHALL be: mode0 colour; mode1 (colour+vga_x) mod 2^CW; mode2 (colour+vga_y) mod 2^CW; mode3 (colour+vga_x+vga_y) mod 2^CW.
REQ-028 done SHALL be 1 exactly in DONE; DONE SHALL persist while start=1 and return to IDLE the cycle after start=0.
REQ-029 Input changes on x0..mode during FILL/DONE SHALL have no effect.
REQ-030 vga_plot SHALL be 0 in IDLE and DONE.

Reset
REQ-031 rst=1 SHALL immediately (no clock needed) force IDLE, done=0, busy=0, vga_plot=0, vga_x=0, vga_y=0, and clear the latched registers.
REQ-032 rst asserted mid-FILL SHALL abort the fill; after release the block SHALL wait in IDLE for a new start with start sampled high only once rst=0.

Verification
REQ-033 Full screen: x0=0,y0=0,w=160,h=120,mode0,colour=5 -> 19200 plots, last (159,119), all colour 5, done one cycle later.
REQ-034 Clipping: x0=150,y0=115,w=20,h=20 -> 10x5=50 plots, x in 150..159, y in 115..119.
REQ-035 Degenerate: w=0 -> done asserted cycle after start, zero plots; x0=200 -> same.
REQ-036 Stall: 4x2 at (10,10), hold high for 3 cycles after 2nd pixel -> 8 plots total, no duplicates, (12,10) follows hold fall.
REQ-037 Modes: 8x2 at (0,0), colour=2, mode3 -> pixel (7,1) colour 2, pixel (3,0) colour 5.
REQ-038 Reset mid-fill after 100 plots -> outputs zero asynchronously; new start then fills from its own x0,y0; done stays high until start drops.
